// File: rtl/jvm_bytecode_sequencer_pkg.sv
// Shared types and constants for the JVM bytecode sequencer.
package jvm_bytecode_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH_OP   = 2'd0,
        FETCH_OPND = 2'd1,
        ITERATE    = 2'd2,
        HALT       = 2'd3
    } seq_state_e;

    localparam logic [7:0] WIDE_OPCODE = 8'hC4;

    localparam int unsigned DEF_PC_W      = 16;
    localparam int unsigned DEF_UADR_W    = 8;
    localparam int unsigned DEF_MAX_OPND  = 4;
    localparam int unsigned DEF_PARAM_LEN = 3;

endpackage

// File: rtl/jvm_bytecode_sequencer_opnd_collector.sv
// Operand shift register with a down-counter flagging the final operand byte.
module jvm_bytecode_sequencer_opnd_collector #(
    parameter int unsigned MAX_OPND = 4,
    parameter int unsigned CNT_W    = $clog2(MAX_OPND + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [CNT_W-1:0]      need_i,
    input  logic                  shift_en_i,
    input  logic [7:0]            byte_i,
    output logic [8*MAX_OPND-1:0] operands_o,
    output logic                  last_o
);

    logic [8*MAX_OPND-1:0] opnd_q, opnd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            opnd_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            opnd_d = '0;
            cnt_d  = need_i;
        end else if (shift_en_i) begin
            opnd_d = {opnd_q[8*MAX_OPND-9:0], byte_i};
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign operands_o = opnd_q;
    assign last_o     = shift_en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/jvm_bytecode_sequencer.sv
// Bytecode fetch, WIDE/operand assembly and microcode chain walk for one JVM instruction at a time.
module jvm_bytecode_sequencer
    import jvm_bytecode_sequencer_pkg::*;
#(
    parameter int unsigned PC_W      = DEF_PC_W,
    parameter int unsigned UADR_W    = DEF_UADR_W,
    parameter int unsigned MAX_OPND  = DEF_MAX_OPND,
    parameter int unsigned PARAM_LEN = DEF_PARAM_LEN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            fetch_data,
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    output logic [PC_W-1:0]       pc,
    input  logic [PARAM_LEN-1:0]  opnd_count,
    input  logic                  opcode_legal,
    output logic [7:0]            jvm_opcode,
    output logic                  is_wide,
    output logic [8*MAX_OPND-1:0] operands,
    output logic [UADR_W-1:0]     uadr,
    output logic                  uadr_valid,
    input  logic [UADR_W-1:0]     next_uadr,
    input  logic                  exec_stall,
    input  logic                  redirect,
    input  logic [PC_W-1:0]       redirect_pc,
    output logic                  instr_done,
    output logic                  illegal,
    output logic [1:0]            state
);

    localparam int unsigned CNT_W = $clog2(MAX_OPND + 1);

    seq_state_e          state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [7:0]          opcode_q, opcode_d;
    logic                wide_q, wide_d;
    logic [UADR_W-1:0]   uadr_q, uadr_d;

    logic                accept;
    logic                wide_byte;
    logic                op_take;
    logic                chain_end;
    logic                opnd_last;
    logic                need_over;
    logic [PARAM_LEN:0]  need_full;
    logic [CNT_W-1:0]    need;

    // need is widened one bit so doubling under WIDE never overflows before the limit check
    assign need_full = {1'b0, opnd_count} << wide_q;
    assign need_over = 32'(need_full) > MAX_OPND;
    assign need      = CNT_W'(need_full);

    assign accept    = fetch_valid && fetch_ready;
    assign wide_byte = (fetch_data == WIDE_OPCODE);
    assign op_take   = accept && (state_q == FETCH_OP) && !wide_byte
                       && opcode_legal && !need_over;
    assign chain_end = (state_q == ITERATE) && !exec_stall && (next_uadr == '0);

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH_OP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_OP: begin
                if (accept) begin
                    if (wide_byte)                        state_d = wide_q ? HALT : FETCH_OP;
                    else if (!opcode_legal || need_over)  state_d = HALT;
                    else if (need == '0)                  state_d = ITERATE;
                    else                                  state_d = FETCH_OPND;
                end
            end
            FETCH_OPND: if (accept && opnd_last) state_d = ITERATE;
            ITERATE:    if (chain_end)           state_d = FETCH_OP;
            HALT:       state_d = HALT;
            default:    state_d = FETCH_OP;
        endcase
        if (redirect) state_d = FETCH_OP;
    end

    always_comb begin
        fetch_ready = 1'b0;
        uadr_valid  = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            FETCH_OP, FETCH_OPND: fetch_ready = !redirect;
            ITERATE: begin
                uadr_valid = 1'b1;
                instr_done = !exec_stall && (next_uadr == '0);
            end
            HALT:    illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        opcode_d = opcode_q;
        wide_d   = wide_q;
        uadr_d   = uadr_q;
        if (accept) pc_d = pc_q + PC_W'(1);
        if (accept && (state_q == FETCH_OP) && wide_byte && !wide_q) wide_d = 1'b1;
        if (op_take) begin
            opcode_d = fetch_data;
            if (need == '0) uadr_d = UADR_W'(fetch_data);
        end
        if (accept && (state_q == FETCH_OPND) && opnd_last) uadr_d = UADR_W'(opcode_q);
        if ((state_q == ITERATE) && !exec_stall && (next_uadr != '0)) uadr_d = next_uadr;
        if (chain_end) wide_d = 1'b0;
        if (redirect) begin
            pc_d   = redirect_pc;
            wide_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            opcode_q <= '0;
            wide_q   <= 1'b0;
            uadr_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            wide_q   <= wide_d;
            uadr_q   <= uadr_d;
        end
    end

    jvm_bytecode_sequencer_opnd_collector #(
        .MAX_OPND (MAX_OPND),
        .CNT_W    (CNT_W)
    ) u_opnd (
        .clk_i      (clk),
        .reset_i    (reset),
        .clear_i    (redirect),
        .load_i     (op_take),
        .need_i     (need),
        .shift_en_i (accept && (state_q == FETCH_OPND)),
        .byte_i     (fetch_data),
        .operands_o (operands),
        .last_o     (opnd_last)
    );

    assign pc         = pc_q;
    assign jvm_opcode = opcode_q;
    assign is_wide    = wide_q;
    assign uadr       = uadr_q;
    assign state      = state_q;

endmodule

// File: tb/tb_jvm_bytecode_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a random program run.
module tb_jvm_bytecode_sequencer;

    localparam int unsigned PC_W      = 16;
    localparam int unsigned UADR_W    = 8;
    localparam int unsigned MAX_OPND  = 4;
    localparam int unsigned PARAM_LEN = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [7:0]            fetch_data;
    logic                  fetch_valid;
    logic                  fetch_ready;
    logic [PC_W-1:0]       pc;
    logic [PARAM_LEN-1:0]  opnd_count;
    logic                  opcode_legal;
    logic [7:0]            jvm_opcode;
    logic                  is_wide;
    logic [8*MAX_OPND-1:0] operands;
    logic [UADR_W-1:0]     uadr;
    logic                  uadr_valid;
    logic [UADR_W-1:0]     next_uadr;
    logic                  exec_stall;
    logic                  redirect;
    logic [PC_W-1:0]       redirect_pc;
    logic                  instr_done;
    logic                  illegal;
    logic [1:0]            state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jvm_bytecode_sequencer #(
        .PC_W      (PC_W),
        .UADR_W    (UADR_W),
        .MAX_OPND  (MAX_OPND),
        .PARAM_LEN (PARAM_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_data   (fetch_data),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .pc           (pc),
        .opnd_count   (opnd_count),
        .opcode_legal (opcode_legal),
        .jvm_opcode   (jvm_opcode),
        .is_wide      (is_wide),
        .operands     (operands),
        .uadr         (uadr),
        .uadr_valid   (uadr_valid),
        .next_uadr    (next_uadr),
        .exec_stall   (exec_stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_done   (instr_done),
        .illegal      (illegal),
        .state        (state)
    );

    // External decode ROM and next-address ROM
    function automatic logic [2:0] rom_count(input logic [7:0] b);
        case (b)
            8'h10, 8'h15: return 3'd1;
            8'h11, 8'h84: return 3'd2;
            8'hC5:        return 3'd3;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic logic rom_legal(input logic [7:0] b);
        case (b)
            8'h00, 8'h60, 8'h10, 8'h11, 8'h15, 8'h84, 8'hC5, 8'hC4: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] rom_next(input logic [7:0] u);
        case (u)
            8'h15:   return 8'h40;
            8'h84:   return 8'h41;
            8'h41:   return 8'h42;
            8'h10:   return 8'h43;
            8'h60:   return 8'h44;
            8'hC5:   return 8'h45;
            8'h45:   return 8'h46;
            default: return 8'h00;
        endcase
    endfunction

    assign opnd_count   = rom_count(fetch_data);
    assign opcode_legal = rom_legal(fetch_data);
    assign next_uadr    = rom_next(uadr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_valid = 1'b0;
        fetch_data  = 8'h00;
        exec_stall  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        fetch_valid = 1'b1;
        fetch_data  = b;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        #1;
        chk({tag, ".state"},  64'(state),       64'(0));
        chk({tag, ".pc"},     64'(pc),          64'(0));
        chk({tag, ".opcode"}, 64'(jvm_opcode),  64'(0));
        chk({tag, ".opnd"},   64'(operands),    64'(0));
        chk({tag, ".uadr"},   64'(uadr),        64'(0));
        chk({tag, ".wide"},   64'(is_wide),     64'(0));
        chk({tag, ".done"},   64'(instr_done),  64'(0));
        chk({tag, ".illeg"},  64'(illegal),     64'(0));
        chk({tag, ".uvalid"}, 64'(uadr_valid),  64'(0));
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [1:0]  e_state;
        logic [15:0] e_pc;
        logic [7:0]  e_op;
        logic        e_wide;
        logic [31:0] e_opnd;
        logic [7:0]  e_uadr;
        logic        e_uv;
        logic        e_done;
        logic        e_rdy;
    } vec_t;

    typedef struct {
        logic [7:0]  op;
        logic        wide;
        logic [31:0] opnd;
        logic [15:0] end_pc;
    } exp_t;

    vec_t       vecs[$];
    exp_t       iq[$];
    logic [7:0] uq[$];
    logic [7:0] mem [256];
    logic [7:0] pick [7];

    initial begin
        int   done_at;
        int   addr;
        int   n;
        int   cyc;
        logic w;
        logic [7:0]  op;
        logic [7:0]  b;
        logic [7:0]  u;
        logic [31:0] val;
        exp_t        e;

        reset = 1'b1;
        idle_inputs();

        // iload 15 03 then wide iinc C4 84 00 05 FF FE, one row per cycle
        //            v     d      st    pc      op     w     opnd          uadr   uv    done  rdy
        vecs.push_back('{1'b1, 8'h15, 2'd0, 16'd0, 8'h00, 1'b0, 32'h00000000, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h03, 2'd1, 16'd1, 8'h15, 1'b0, 32'h00000000, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 2'd2, 16'd2, 8'h15, 1'b0, 32'h00000003, 8'h15, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 2'd2, 16'd2, 8'h15, 1'b0, 32'h00000003, 8'h40, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 2'd0, 16'd2, 8'h15, 1'b0, 32'h00000003, 8'h40, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'hC4, 2'd0, 16'd2, 8'h15, 1'b0, 32'h00000003, 8'h40, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h84, 2'd0, 16'd3, 8'h15, 1'b1, 32'h00000003, 8'h40, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h00, 2'd1, 16'd4, 8'h84, 1'b1, 32'h00000000, 8'h40, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h05, 2'd1, 16'd5, 8'h84, 1'b1, 32'h00000000, 8'h40, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'hFF, 2'd1, 16'd6, 8'h84, 1'b1, 32'h00000005, 8'h40, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'hFE, 2'd1, 16'd7, 8'h84, 1'b1, 32'h000005FF, 8'h40, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 2'd2, 16'd8, 8'h84, 1'b1, 32'h0005FFFE, 8'h84, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 2'd2, 16'd8, 8'h84, 1'b1, 32'h0005FFFE, 8'h41, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 2'd2, 16'd8, 8'h84, 1'b1, 32'h0005FFFE, 8'h42, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 2'd0, 16'd8, 8'h84, 1'b0, 32'h0005FFFE, 8'h42, 1'b0, 1'b0, 1'b1});

        do_reset();
        chk_reset_state("rst");
        chk("rst.ready", 64'(fetch_ready), 64'(1));

        foreach (vecs[i]) begin
            fetch_valid = vecs[i].v;
            fetch_data  = vecs[i].d;
            #1;
            chk($sformatf("v%0d.state", i), 64'(state),       64'(vecs[i].e_state));
            chk($sformatf("v%0d.pc", i),    64'(pc),          64'(vecs[i].e_pc));
            chk($sformatf("v%0d.op", i),    64'(jvm_opcode),  64'(vecs[i].e_op));
            chk($sformatf("v%0d.wide", i),  64'(is_wide),     64'(vecs[i].e_wide));
            chk($sformatf("v%0d.opnd", i),  64'(operands),    64'(vecs[i].e_opnd));
            chk($sformatf("v%0d.uadr", i),  64'(uadr),        64'(vecs[i].e_uadr));
            chk($sformatf("v%0d.uv", i),    64'(uadr_valid),  64'(vecs[i].e_uv));
            chk($sformatf("v%0d.done", i),  64'(instr_done),  64'(vecs[i].e_done));
            chk($sformatf("v%0d.rdy", i),   64'(fetch_ready), 64'(vecs[i].e_rdy));
            tick();
        end
        idle_inputs();

        // Fetch gaps and execution stall stretch the iload by exactly five cycles
        do_reset();
        done_at = -1;
        for (int c = 0; c < 14; c++) begin
            fetch_valid = (c == 0) || (c == 4);
            fetch_data  = (c == 0) ? 8'h15 : 8'h03;
            exec_stall  = (c == 5) || (c == 6);
            #1;
            if (c >= 1 && c <= 3) begin
                chk("gap.pc",    64'(pc),       64'(1));
                chk("gap.state", 64'(state),    64'(1));
                chk("gap.opnd",  64'(operands), 64'(0));
            end
            if (c == 5 || c == 6) begin
                chk("stall.uadr", 64'(uadr),       64'(8'h15));
                chk("stall.done", 64'(instr_done), 64'(0));
            end
            if (instr_done && done_at < 0) done_at = c;
            tick();
        end
        idle_inputs();
        chk("gap.done_cycle", 64'(done_at), 64'(8));
        chk("gap.pc_end",     64'(pc),      64'(2));

        // Redirect during the second sipush operand byte
        do_reset();
        feed(8'h11);
        feed(8'h12);
        fetch_valid = 1'b1;
        fetch_data  = 8'h34;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        chk("redir.ready_low", 64'(fetch_ready), 64'(0));
        chk("redir.opnd_pre",  64'(operands),    64'(8'h12));
        tick();
        idle_inputs();
        #1;
        chk("redir.pc",    64'(pc),       64'(16'h0100));
        chk("redir.state", 64'(state),    64'(0));
        chk("redir.opnd",  64'(operands), 64'(0));
        done_at = 0;
        for (int c = 0; c < 4; c++) begin
            if (instr_done) done_at++;
            tick();
        end
        chk("redir.no_done", 64'(done_at), 64'(0));
        feed(8'hC4);
        chk("redir.wide_set", 64'(is_wide), 64'(1));
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        idle_inputs();
        chk("redir.wide_clr", 64'(is_wide), 64'(0));
        chk("redir.pc2",      64'(pc),      64'(16'h0200));

        // Double WIDE halts; only redirect leaves HALT
        do_reset();
        feed(8'hC4);
        feed(8'hC4);
        fetch_valid = 1'b1;
        fetch_data  = 8'h00;
        #1;
        chk("halt.state", 64'(state),       64'(3));
        chk("halt.illeg", 64'(illegal),     64'(1));
        chk("halt.ready", 64'(fetch_ready), 64'(0));
        chk("halt.uv",    64'(uadr_valid),  64'(0));
        tick();
        tick();
        chk("halt.pc_hold", 64'(pc),    64'(2));
        chk("halt.stay",    64'(state), 64'(3));
        fetch_valid = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        idle_inputs();
        chk("halt.exit_state", 64'(state),   64'(0));
        chk("halt.exit_illeg", 64'(illegal), 64'(0));
        chk("halt.exit_pc",    64'(pc),      64'(16'h0020));
        feed(8'hFF);
        chk("illop.state", 64'(state),   64'(3));
        chk("illop.illeg", 64'(illegal), 64'(1));
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        idle_inputs();
        chk("illop.exit", 64'(state), 64'(0));
        feed(8'hC4);
        feed(8'hC5);
        chk("over.state", 64'(state), 64'(3));
        redirect = 1'b1;
        tick();
        idle_inputs();
        feed(8'hC5);
        chk("need3.state", 64'(state), 64'(1));

        // Reset mid-ITERATE, also overriding a simultaneous redirect
        do_reset();
        feed(8'h15);
        feed(8'h03);
        tick();
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0055;
        #1;
        chk("midrst.uadr_pre",  64'(uadr),  64'(8'h40));
        chk("midrst.state_pre", 64'(state), 64'(2));
        chk("midrst.pc_pre",    64'(pc),    64'(2));
        tick();
        reset    = 1'b0;
        redirect = 1'b0;
        chk_reset_state("midrst");

        // Random program against the instruction-level model
        pick = '{8'h00, 8'h60, 8'h10, 8'h15, 8'h11, 8'h84, 8'hC5};
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        addr = 0;
        while (addr < 220) begin
            op = pick[$urandom_range(0, 6)];
            n  = int'(rom_count(op));
            w  = (n <= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (w) begin
                mem[addr] = 8'hC4;
                addr++;
            end
            mem[addr] = op;
            addr++;
            if (w) n = 2 * n;
            val = '0;
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                mem[addr] = b;
                addr++;
                val = {val[23:0], b};
            end
            iq.push_back('{op, w, val, addr[15:0]});
            u = op;
            uq.push_back(u);
            while (rom_next(u) != 8'h00) begin
                u = rom_next(u);
                uq.push_back(u);
            end
        end

        do_reset();
        cyc = 0;
        while (iq.size() > 0 && cyc < 5000) begin
            fetch_valid = ($urandom_range(0, 3) != 0);
            fetch_data  = mem[pc[7:0]];
            exec_stall  = ($urandom_range(0, 3) == 0);
            #1;
            if (illegal) begin
                chk("rnd.illegal", 64'(illegal), 64'(0));
                break;
            end
            if (uadr_valid) begin
                if (uq.size() > 0) begin
                    chk("rnd.uadr", 64'(uadr), 64'(uq[0]));
                    if (!exec_stall) void'(uq.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL rnd.uadr_extra got %0h want none", uadr);
                end
            end
            if (instr_done) begin
                e = iq.pop_front();
                chk("rnd.opcode", 64'(jvm_opcode), 64'(e.op));
                chk("rnd.wide",   64'(is_wide),    64'(e.wide));
                chk("rnd.opnd",   64'(operands),   64'(e.opnd));
                chk("rnd.pc",     64'(pc),         64'(e.end_pc));
            end
            tick();
            cyc++;
        end
        idle_inputs();
        chk("rnd.all_retired", 64'(iq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
